// File: rtl/router_egress_arb.sv
// Round-robin, packet-atomic egress scheduler draining three router FIFOs onto one valid/ready byte stream.
// Define ARB_PARITY_CHECK_EN to add the parity_err output and its check logic.
module router_egress_arb #(
  parameter int DW    = 8,
  parameter int LEN_W = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [2:0]    vld_in,
  input  logic [DW-1:0] data_in_0,
  input  logic [DW-1:0] data_in_1,
  input  logic [DW-1:0] data_in_2,
  output logic [2:0]    read_enb,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          m_sop,
  output logic          m_eop,
  output logic [2:0]    grant,
  output logic          busy
`ifdef ARB_PARITY_CHECK_EN
  ,
  output logic          parity_err
`endif
);

  localparam int CW = LEN_W + 1;

  typedef enum logic [1:0] {IDLE, XFER, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [1:0]      gidx_q, gidx_d;
  logic [1:0]      last_q, last_d;
  logic [CW-1:0]   issued_q, issued_d;
  logic [CW-1:0]   total_q, total_d;
  logic            known_q, known_d;
  logic [CW-1:0]   ret_q, ret_d;
  logic            inflight_q, inflight_d;

  logic [DW+1:0]   mem_q [2];
  logic            wr_q, rd_q;
  logic [1:0]      cnt_q;

  logic [DW-1:0]   ret_data;
  logic [DW+1:0]   head;
  logic            pop;
  logic [1:0]      occ;
  logic [CW-1:0]   limit;
  logic            rd_ok;
  logic            in_sop, in_eop;

  function automatic logic [1:0] rr_pick(input logic [2:0] req, input logic [1:0] last);
    logic [1:0] c;
    logic [1:0] sel;
    logic       hit;
    c   = last;
    sel = 2'd0;
    hit = 1'b0;
    for (int k = 0; k < 3; k++) begin
      c = (c == 2'd2) ? 2'd0 : c + 2'd1;
      if (req[c] && !hit) begin
        sel = c;
        hit = 1'b1;
      end
    end
    return sel;
  endfunction

  assign ret_data = (gidx_q == 2'd0) ? data_in_0 : (gidx_q == 2'd1) ? data_in_1 : data_in_2;
  assign head     = mem_q[rd_q];
  assign m_valid  = (cnt_q != 2'd0);
  assign m_data   = head[DW-1:0];
  assign m_eop    = head[DW];
  assign m_sop    = head[DW+1];
  assign pop      = m_valid && m_ready;

  // Occupancy counts the slot freed by this cycle's handoff so a full-rate stream never stalls.
  assign occ      = cnt_q + {1'b0, inflight_q} - {1'b0, pop};
  // Until the header comes back only the 2-byte minimum packet is known to exist.
  assign limit    = known_q ? total_q : CW'(2);
  assign rd_ok    = (state_q == XFER) && vld_in[gidx_q] && (issued_q < limit) && (occ < 2'd2);
  assign read_enb = rd_ok ? (3'b001 << gidx_q) : 3'b000;
  assign grant    = (state_q != IDLE) ? (3'b001 << gidx_q) : 3'b000;
  assign busy     = (state_q != IDLE);

  assign in_sop   = (ret_q == '0);
  assign in_eop   = known_q && (ret_q == total_q - CW'(1));

  always_comb begin
    state_d    = state_q;
    gidx_d     = gidx_q;
    last_d     = last_q;
    issued_d   = issued_q + CW'(rd_ok);
    ret_d      = ret_q + CW'(inflight_q);
    total_d    = total_q;
    known_d    = known_q;
    inflight_d = rd_ok;
    if (inflight_q && in_sop) begin
      total_d = CW'(ret_data[DW-1 -: LEN_W]) + CW'(2);
      known_d = 1'b1;
    end
    case (state_q)
      IDLE: begin
        if (|vld_in) begin
          state_d  = XFER;
          gidx_d   = rr_pick(vld_in, last_q);
          issued_d = '0;
          ret_d    = '0;
          total_d  = '0;
          known_d  = 1'b0;
        end
      end
      XFER: begin
        if (known_q && (issued_q == total_q)) state_d = DRAIN;
      end
      DRAIN: begin
        if (pop && m_eop) begin
          state_d = IDLE;
          last_d  = gidx_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      gidx_q     <= 2'd0;
      last_q     <= 2'd2;
      issued_q   <= '0;
      total_q    <= '0;
      known_q    <= 1'b0;
      ret_q      <= '0;
      inflight_q <= 1'b0;
      mem_q[0]   <= '0;
      mem_q[1]   <= '0;
      wr_q       <= 1'b0;
      rd_q       <= 1'b0;
      cnt_q      <= 2'd0;
    end else begin
      state_q    <= state_d;
      gidx_q     <= gidx_d;
      last_q     <= last_d;
      issued_q   <= issued_d;
      total_q    <= total_d;
      known_q    <= known_d;
      ret_q      <= ret_d;
      inflight_q <= inflight_d;
      if (inflight_q) begin
        mem_q[wr_q] <= {in_sop, in_eop, ret_data};
        wr_q        <= ~wr_q;
      end
      if (pop) rd_q <= ~rd_q;
      cnt_q <= cnt_q + {1'b0, inflight_q} - {1'b0, pop};
    end
  end

`ifdef ARB_PARITY_CHECK_EN
  logic [DW-1:0] par_acc_q;
  logic          parity_err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      par_acc_q    <= '0;
      parity_err_q <= 1'b0;
    end else begin
      parity_err_q <= pop && m_eop && (par_acc_q != m_data);
      if (pop && m_sop)       par_acc_q <= m_data;
      else if (pop && !m_eop) par_acc_q <= par_acc_q ^ m_data;
    end
  end

  assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_router_egress_arb.sv
// Bench for router_egress_arb: FIFO models feed the arbiter, a byte scoreboard checks the egress stream.
`timescale 1ns/1ps
module tb_router_egress_arb;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [2:0] vld_in;
  logic [7:0] data_in_0, data_in_1, data_in_2;
  logic [2:0] read_enb;
  logic       m_valid, m_ready;
  logic [7:0] m_data;
  logic       m_sop, m_eop;
  logic [2:0] grant;
  logic       busy;
`ifdef ARB_PARITY_CHECK_EN
  logic       parity_err;
`endif

  router_egress_arb dut (
    .clk       (clk),
    .reset     (reset),
    .vld_in    (vld_in),
    .data_in_0 (data_in_0),
    .data_in_1 (data_in_1),
    .data_in_2 (data_in_2),
    .read_enb  (read_enb),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_sop     (m_sop),
    .m_eop     (m_eop),
    .grant     (grant),
    .busy      (busy)
`ifdef ARB_PARITY_CHECK_EN
    ,
    .parity_err(parity_err)
`endif
  );

  typedef struct packed {
    logic [7:0] d;
    logic       sop;
    logic       eop;
    logic [2:0] g;
  } exp_t;

  typedef struct {
    int         ch;
    int         len;
    logic [2:0] g;
    int         nbytes;
  } vec_t;

  exp_t       sb [$];
  logic [7:0] fq [3][$];
  logic [2:0] gate;
  logic [7:0] pend [3];
  logic [2:0] pend_v;
  logic [2:0] re_s;
  logic [1:0] mv_s;
  logic       sop_hand;
  int         checks = 0;
  int         errors = 0;
  int         n_hand = 0;
  int         n_perr = 0;
  int         rd_cnt [3];
  vec_t       tbl [5];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
    end
  endtask

  task automatic update_vld();
    for (int i = 0; i < 3; i++) vld_in[i] = (fq[i].size() != 0) && !gate[i];
  endtask

  // One clock: sample and score at the falling edge, then return data for last cycle's reads after the rise.
  task automatic cyc();
    exp_t e, a;
    @(negedge clk);
    re_s     = read_enb;
    mv_s     = {m_valid, m_sop};
    sop_hand = m_valid && m_ready && m_sop;
    check("rd_legal", {28'd0, !$onehot0(re_s), re_s & ~vld_in}, 32'd0);
    if (m_valid && m_ready) begin
      n_hand++;
      a = '{d: m_data, sop: m_sop, eop: m_eop, g: grant};
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_byte actual=%0h required=none t=%0t", a, $time);
      end else begin
        e = sb.pop_front();
        check("byte", {19'd0, a}, {19'd0, e});
      end
    end
`ifdef ARB_PARITY_CHECK_EN
    if (parity_err) n_perr++;
`endif
    for (int i = 0; i < 3; i++) begin
      pend_v[i] = re_s[i];
      if (re_s[i]) begin
        rd_cnt[i]++;
        if (fq[i].size() != 0) pend[i] = fq[i].pop_front();
      end
    end
    @(posedge clk);
    #1;
    if (pend_v[0]) data_in_0 = pend[0];
    if (pend_v[1]) data_in_1 = pend[1];
    if (pend_v[2]) data_in_2 = pend[2];
    update_vld();
  endtask

  task automatic flush_model();
    sb.delete();
    for (int i = 0; i < 3; i++) begin
      fq[i].delete();
      rd_cnt[i] = 0;
    end
    gate = 3'b000;
    update_vld();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    flush_model();
    cyc();
    cyc();
    reset = 1'b0;
    flush_model();
    n_perr = 0;
  endtask

  task automatic load_pkt(input int ch, input int len, input logic [2:0] g, input logic bad,
                          input logic [7:0] pay0);
    logic [7:0] b, par;
    b   = 8'(len << 2);
    par = b;
    fq[ch].push_back(b);
    sb.push_back('{d: b, sop: 1'b1, eop: 1'b0, g: g});
    for (int k = 0; k < len; k++) begin
      b   = (k == 0) ? pay0 : 8'($urandom);
      par = par ^ b;
      fq[ch].push_back(b);
      sb.push_back('{d: b, sop: 1'b0, eop: 1'b0, g: g});
    end
    par = par ^ {7'd0, bad};
    fq[ch].push_back(par);
    sb.push_back('{d: par, sop: 1'b0, eop: 1'b1, g: g});
    update_vld();
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while ((sb.size() != 0 || busy) && k < budget) begin
      cyc();
      k++;
    end
    check("drain_in_budget", {31'd0, (k < budget)}, 32'd1);
  endtask

  initial begin
    int h0, k;
    reset     = 1'b1;
    m_ready   = 1'b1;
    gate      = 3'b000;
    pend_v    = 3'b000;
    vld_in    = 3'b000;
    data_in_0 = 8'h00;
    data_in_1 = 8'h00;
    data_in_2 = 8'h00;

    tbl[0] = '{ch: 1, len: 0,  g: 3'b010, nbytes: 2};
    tbl[1] = '{ch: 2, len: 5,  g: 3'b100, nbytes: 7};
    tbl[2] = '{ch: 0, len: 1,  g: 3'b001, nbytes: 3};
    tbl[3] = '{ch: 2, len: 63, g: 3'b100, nbytes: 65};
    tbl[4] = '{ch: 1, len: 4,  g: 3'b010, nbytes: 6};

    do_reset();
    check("reset_outs", {16'd0, read_enb, m_valid, m_data, m_sop, m_eop, grant, busy}, 32'd0);

    // Single ch0 packet, header 0C: five back-to-back reads, header on the egress three cycles after request.
    load_pkt(0, 3, 3'b001, 1'b0, 8'($urandom));
    for (int c = 0; c < 8; c++) begin
      cyc();
      check($sformatf("t1_read_enb_c%0d", c), {29'd0, re_s}, (c >= 1 && c <= 5) ? 32'd1 : 32'd0);
      if (c == 2) check("t1_no_valid_c2", {30'd0, mv_s}, 32'd0);
      if (c == 3) check("t1_sop_c3", {30'd0, mv_s}, 32'd3);
    end
    wait_idle(50);
    check("t1_reads", rd_cnt[0], 32'd5);

    for (int i = 0; i < 5; i++) begin
      h0 = n_hand;
      load_pkt(tbl[i].ch, tbl[i].len, tbl[i].g, 1'b0, 8'($urandom));
      wait_idle(200);
      check($sformatf("tbl%0d_bytes", i), n_hand - h0, tbl[i].nbytes);
      check($sformatf("tbl%0d_idle", i), {28'd0, grant, busy}, 32'd0);
    end

    // All three channels request together, two rounds: service order ch0, ch1, ch2 both times.
    do_reset();
    for (int r = 0; r < 2; r++) begin
      load_pkt(0, 0, 3'b001, 1'b0, 8'h00);
      load_pkt(1, 0, 3'b010, 1'b0, 8'h00);
      load_pkt(2, 0, 3'b100, 1'b0, 8'h00);
      wait_idle(100);
    end

    // Sink stall right after sop: reads stop while the skid is full, nothing lost.
    h0 = n_hand;
    load_pkt(0, 2, 3'b001, 1'b0, 8'($urandom));
    k = 0;
    sop_hand = 1'b0;
    while (!sop_hand && k < 20) begin
      cyc();
      k++;
    end
    check("t3_sop_seen", {31'd0, sop_hand}, 32'd1);
    m_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      cyc();
      check($sformatf("t3_hold_s%0d", s), {31'd0, mv_s[1]}, 32'd1);
      if (s >= 1) check($sformatf("t3_no_read_s%0d", s), {29'd0, re_s}, 32'd0);
    end
    m_ready = 1'b1;
    wait_idle(50);
    check("t3_bytes", n_hand - h0, 32'd4);

    // ch1 writer falls behind mid-payload for four cycles.
    h0 = n_hand;
    load_pkt(1, 6, 3'b010, 1'b0, 8'($urandom));
    for (int c = 0; c < 4; c++) cyc();
    gate = 3'b010;
    update_vld();
    for (int s = 0; s < 4; s++) begin
      cyc();
      check($sformatf("t4_gap_s%0d", s), {31'd0, re_s[1]}, 32'd0);
      check($sformatf("t4_busy_s%0d", s), {31'd0, busy}, 32'd1);
    end
    gate = 3'b000;
    update_vld();
    wait_idle(60);
    check("t4_bytes", n_hand - h0, 32'd8);

    // Reset in the middle of a ch2 payload, then a fresh packet must open with sop.
    load_pkt(2, 8, 3'b100, 1'b0, 8'($urandom));
    for (int c = 0; c < 6; c++) cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    flush_model();
    check("t5_after_reset", {27'd0, grant, m_valid, busy}, 32'd0);
    h0 = n_hand;
    load_pkt(2, 1, 3'b100, 1'b0, 8'($urandom));
    wait_idle(50);
    check("t5_bytes", n_hand - h0, 32'd3);

`ifdef ARB_PARITY_CHECK_EN
    do_reset();
    load_pkt(0, 1, 3'b001, 1'b0, 8'h55);
    wait_idle(50);
    cyc();
    cyc();
    check("t6_good_parity", n_perr, 32'd0);
    load_pkt(0, 1, 3'b001, 1'b1, 8'h55);
    wait_idle(50);
    cyc();
    cyc();
    check("t6_bad_parity", n_perr, 32'd1);
`endif

    check("sb_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
